// File: rtl/load_store_unit.sv
// Memory stage behind integer_unit: one load or store at a time over a req/gnt/rvalid bus,
// with byte-lane alignment, load extension and a single-cycle writeback beat.
//
// state | meaning
// IDLE  | ready for a new op from execute
// REQ   | bus request held until granted
// RESP  | waiting for the response beat
// DONE  | one-cycle writeback / exception pulse
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_ex_valid,
  output logic            o_ex_ready,
  input  logic [XLEN-1:0] i_ex_addr,
  input  logic [XLEN-1:0] i_ex_wdata,
  input  logic [2:0]      i_ex_funct3,
  input  logic            i_ex_load,
  input  logic            i_ex_store,
  input  logic [4:0]      i_ex_rd,
  output logic            o_mem_req,
  input  logic            i_mem_gnt,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [3:0]      o_mem_be,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic            i_mem_err,
  output logic            o_wb_valid,
  output logic            o_wb_we,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_exc_misalign,
  output logic            o_exc_fault
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            load_q, misalign_q, err_q;

  logic            accept, ex_active, ex_misalign;
  logic [1:0]      sh;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_rep, rdata_sh, load_ext;

  assign accept    = i_ex_valid && (state == IDLE);
  assign ex_active = i_ex_load || i_ex_store;

  // funct3[1:0] selects width: 00 byte, 01 half, anything else word
  always_comb begin
    ex_misalign = 1'b0;
    case (i_ex_funct3[1:0])
      2'b00:   ex_misalign = 1'b0;
      2'b01:   ex_misalign = i_ex_addr[0];
      default: ex_misalign = |i_ex_addr[1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      load_q     <= 1'b0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept && ex_active) begin
        addr_q     <= i_ex_addr;
        wdata_q    <= i_ex_wdata;
        funct3_q   <= i_ex_funct3;
        rd_q       <= i_ex_rd;
        load_q     <= i_ex_load;
        misalign_q <= ex_misalign;
        err_q      <= 1'b0;
      end
      if (state == RESP && i_mem_rvalid) begin
        rdata_q <= i_mem_rdata;
        err_q   <= i_mem_err;
      end
    end
  end

  assign sh       = addr_q[1:0];
  assign rdata_sh = rdata_q >> {sh, 3'b000};

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata_q;
    load_ext  = rdata_sh;
    case (funct3_q[1:0])
      2'b00: begin
        be        = 4'b0001 << sh;
        wdata_rep = {4{wdata_q[7:0]}};
        load_ext  = funct3_q[2] ? {{(XLEN-8){1'b0}}, rdata_sh[7:0]}
                                : {{(XLEN-8){rdata_sh[7]}}, rdata_sh[7:0]};
      end
      2'b01: begin
        be        = 4'b0011 << sh;
        wdata_rep = {2{wdata_q[15:0]}};
        load_ext  = funct3_q[2] ? {{(XLEN-16){1'b0}}, rdata_sh[15:0]}
                                : {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata_q;
        load_ext  = rdata_sh;
      end
    endcase
  end

  always_comb begin
    state_nxt      = state;
    o_ex_ready     = (state == IDLE);
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr     = '0;
    o_mem_be       = 4'b0000;
    o_mem_wdata    = '0;
    o_wb_valid     = 1'b0;
    o_wb_we        = 1'b0;
    o_wb_rd        = '0;
    o_wb_data      = '0;
    o_exc_misalign = 1'b0;
    o_exc_fault    = 1'b0;
    case (state)
      IDLE: begin
        if (accept && ex_active) state_nxt = ex_misalign ? DONE : REQ;
      end
      REQ: begin
        o_mem_req   = 1'b1;
        o_mem_we    = !load_q;
        o_mem_addr  = {addr_q[XLEN-1:2], 2'b00};
        o_mem_be    = be;
        o_mem_wdata = wdata_rep;
        if (i_mem_gnt) state_nxt = RESP;
      end
      // rvalid is only looked at here, so a beat coincident with gnt is dropped
      RESP: begin
        if (i_mem_rvalid) state_nxt = DONE;
      end
      DONE: begin
        o_wb_valid     = 1'b1;
        o_wb_we        = load_q && !err_q && !misalign_q && (rd_q != 5'd0);
        o_wb_rd        = rd_q;
        o_wb_data      = load_ext;
        o_exc_misalign = misalign_q;
        o_exc_fault    = err_q;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a randomizing bus responder, a byte-level reference
// model computing expected bus beats and writebacks, and a reset-abort scenario.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_ex_valid, o_ex_ready;
  logic [31:0] i_ex_addr, i_ex_wdata;
  logic [2:0]  i_ex_funct3;
  logic        i_ex_load, i_ex_store;
  logic [4:0]  i_ex_rd;
  logic        o_mem_req, i_mem_gnt, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_rvalid, i_mem_err;
  logic        o_wb_valid, o_wb_we;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_exc_misalign, o_exc_fault;

  // bus inputs come from the responder, or from the reset scenario when manual is set
  logic        r_gnt = 0, r_rvalid = 0, r_err = 0, m_gnt = 0, m_rvalid = 0, m_err = 0;
  logic [31:0] r_rdata = 0, m_rdata = 0;
  bit          manual = 0;
  assign i_mem_gnt    = manual ? m_gnt    : r_gnt;
  assign i_mem_rvalid = manual ? m_rvalid : r_rvalid;
  assign i_mem_rdata  = manual ? m_rdata  : r_rdata;
  assign i_mem_err    = manual ? m_err    : r_err;

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn),
    .i_ex_valid(i_ex_valid), .o_ex_ready(o_ex_ready), .i_ex_addr(i_ex_addr),
    .i_ex_wdata(i_ex_wdata), .i_ex_funct3(i_ex_funct3), .i_ex_load(i_ex_load),
    .i_ex_store(i_ex_store), .i_ex_rd(i_ex_rd),
    .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .i_mem_err(i_mem_err),
    .o_wb_valid(o_wb_valid), .o_wb_we(o_wb_we), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .o_exc_misalign(o_exc_misalign), .o_exc_fault(o_exc_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    int          gnt_dly;
    int          rv_dly;
    bit          stray;
    logic [31:0] rdata;
    logic        err;
  } bus_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        fault;
    int          cyc;
  } wb_t;

  bus_t bus_q[$];
  wb_t  wb_q[$];
  int   n_cmp = 0, n_err = 0, rsp_cyc = 0, wb_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int op_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Reference model: works lane by lane from the access size and byte offset.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                       input logic ld, input logic st, input logic [4:0] rd,
                       input logic [31:0] rdata, input logic err,
                       input int gd, input int rvd, input bit stray);
    int     t = 0;
    int     s, off;
    bit     mis;
    bus_t   b;
    wb_t    w;
    longint v;
    while (!o_ex_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("ex_ready_before_issue", o_ex_ready, 1'b1);
    s   = op_size(f3);
    off = int'(addr[1:0]);
    mis = (off % s) != 0;
    i_ex_valid = 1; i_ex_addr = addr; i_ex_wdata = wdata; i_ex_funct3 = f3;
    i_ex_load = ld; i_ex_store = st; i_ex_rd = rd;
    if (ld || st) begin
      if (!mis) begin
        b.addr = addr & 32'hFFFF_FFFC;
        b.we   = !ld;
        for (int i = 0; i < 4; i++) begin
          b.be[i] = (i >= off) && (i < off + s);
          b.wdata[8*i +: 8] = wdata[8*(i % s) +: 8];
        end
        b.gnt_dly = gd; b.rv_dly = rvd; b.stray = stray; b.rdata = rdata; b.err = err;
        bus_q.push_back(b);
      end
      v = 0;
      if (!mis) begin
        for (int k = 0; k < s; k++) v = v | (longint'(rdata[8*(off+k) +: 8]) << (8*k));
        if (s < 4 && !f3[2] && v[8*s-1]) v = v - (longint'(1) << (8*s));
      end
      w.data  = v[31:0];
      w.mis   = mis;
      w.fault = !mis && err;
      w.we    = ld && !mis && !err && (rd != 0);
      w.rd    = rd;
      w.cyc   = cyc + 1;
      wb_q.push_back(w);
    end
    @(negedge clk);
    i_ex_valid = 0;
  endtask

  // Bus responder
  initial begin
    bus_t p;
    forever begin
      @(negedge clk);
      if (!manual && rstn && o_mem_req) begin
        if (bus_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_mem_req: actual req=1 required no request (t=%0t)", $time);
          r_gnt = 1;
          @(negedge clk);
          r_gnt = 0;
        end else begin
          p = bus_q.pop_front();
          chk("mem_addr", o_mem_addr, p.addr);
          chk("mem_we", o_mem_we, p.we);
          chk("mem_be", o_mem_be, p.be);
          chk("mem_wdata", o_mem_wdata, p.wdata);
          for (int i = 0; i < p.gnt_dly; i++) begin
            r_gnt = 0;
            @(negedge clk);
            chk("req_hold", o_mem_req, 1'b1);
            chk("addr_hold", o_mem_addr, p.addr);
            chk("be_hold", o_mem_be, p.be);
            chk("wdata_hold", o_mem_wdata, p.wdata);
          end
          r_gnt = 1;
          if (p.stray) begin
            r_rvalid = 1; r_rdata = ~p.rdata; r_err = 1;
          end
          @(negedge clk);
          r_gnt = 0; r_rvalid = 0; r_err = 0;
          chk("req_dropped_after_gnt", o_mem_req, 1'b0);
          repeat (p.rv_dly) @(negedge clk);
          r_rvalid = 1; r_rdata = p.rdata; r_err = p.err;
          rsp_cyc = cyc;
          @(negedge clk);
          r_rvalid = 0; r_err = 0; r_rdata = $urandom;
        end
      end
    end
  end

  // Writeback monitor
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (rstn && o_wb_valid) begin
        wb_seen++;
        if (wb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_wb: actual wb_valid=1 required no completion (t=%0t)", $time);
        end else begin
          e = wb_q.pop_front();
          chk("wb_we", o_wb_we, e.we);
          chk("wb_rd", o_wb_rd, e.rd);
          if (e.we) chk("wb_data", o_wb_data, e.data);
          chk("exc_misalign", o_exc_misalign, e.mis);
          chk("exc_fault", o_exc_fault, e.fault);
          chk("wb_cycle", cyc, e.mis ? e.cyc : rsp_cyc + 1);
        end
      end
    end
  end

  initial begin
    int          t, seen0;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [4:0]  rd;
    logic        ld, st;
    int          k, s;
    rstn = 0; i_ex_valid = 0; i_ex_addr = 0; i_ex_wdata = 0; i_ex_funct3 = 0;
    i_ex_load = 0; i_ex_store = 0; i_ex_rd = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_ex_ready", o_ex_ready, 1'b1);
    chk("rst_mem_req", o_mem_req, 1'b0);
    chk("rst_mem_we", o_mem_we, 1'b0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_mem_be", o_mem_be, 4'h0);
    chk("rst_mem_wdata", o_mem_wdata, 32'h0);
    chk("rst_wb", {o_wb_valid, o_wb_we, o_exc_misalign, o_exc_fault}, 4'h0);
    chk("rst_wb_rd", o_wb_rd, 5'h0);
    chk("rst_wb_data", o_wb_data, 32'h0);
    rstn = 1;
    @(negedge clk);

    // directed cases
    issue(32'h100, 32'h0, 3'b010, 1, 0, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
    issue(32'h103, 32'h0, 3'b000, 1, 0, 5'd7, 32'h80AA55CC, 0, 1, 1, 0);
    issue(32'h103, 32'h0, 3'b100, 1, 0, 5'd7, 32'h80AA55CC, 0, 0, 2, 1);
    issue(32'h102, 32'h1234ABCD, 3'b001, 0, 1, 5'd3, 32'h0, 0, 0, 0, 0);
    issue(32'h101, 32'h0, 3'b010, 1, 0, 5'd9, 32'h0, 0, 0, 0, 0);
    issue(32'h200, 32'h0, 3'b010, 1, 0, 5'd4, 32'h11223344, 1, 3, 1, 1);
    issue(32'h300, 32'h0, 3'b010, 0, 0, 5'd4, 32'h0, 0, 0, 0, 0);
    issue(32'h302, 32'h0, 3'b101, 1, 1, 5'd0, 32'h8001FFFF, 0, 0, 0, 0);

    for (int n = 0; n < 250; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      s  = op_size(f3);
      if ($urandom_range(0, 3) != 0) begin
        if (s == 4) a[1:0] = 2'b00;
        else if (s == 2) a[0] = 1'b0;
      end
      k  = $urandom_range(0, 9);
      ld = (k < 5) || (k == 8);
      st = (k >= 5 && k < 9);
      rd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) rd = 0;
      issue(a, $urandom, f3, ld, st, rd, $urandom, $urandom_range(0, 5) == 0,
            $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end

    t = 0;
    while ((wb_q.size() != 0 || !o_ex_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_wb_queue", wb_q.size(), 0);
    chk("drain_bus_queue", bus_q.size(), 0);

    // reset aborts a transaction in REQ and in RESP
    manual = 1;
    seen0  = wb_seen;
    i_ex_valid = 1; i_ex_addr = 32'h40; i_ex_funct3 = 3'b010; i_ex_load = 1; i_ex_store = 0;
    i_ex_rd = 5'd6;
    @(negedge clk);
    i_ex_valid = 0;
    chk("abort_req_up", o_mem_req, 1'b1);
    #1 rstn = 0;
    #1;
    chk("abort_req_async_drop", o_mem_req, 1'b0);
    chk("abort_req_ready", o_ex_ready, 1'b1);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    i_ex_valid = 1;
    @(negedge clk);
    i_ex_valid = 0;
    chk("abort_resp_req_up", o_mem_req, 1'b1);
    m_gnt = 1;
    @(negedge clk);
    m_gnt = 0;
    chk("abort_resp_busy", o_ex_ready, 1'b0);
    #1 rstn = 0;
    #1;
    chk("abort_resp_req", o_mem_req, 1'b0);
    chk("abort_resp_ready", o_ex_ready, 1'b1);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    m_rvalid = 1; m_rdata = 32'hCAFEF00D;
    @(negedge clk);
    m_rvalid = 0;
    repeat (5) @(negedge clk);
    chk("stray_rvalid_no_wb", wb_seen, seen0);
    chk("stray_rvalid_ready", o_ex_ready, 1'b1);
    chk("stray_rvalid_req", o_mem_req, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
